// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames go out back-to-back, LSB first, optional parity.
// A write to an empty idle block drives the start bit one cycle later; writes while full are dropped.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wr_vld_i,
    input  logic [DATA_BITS-1:0]          wr_dat_i,
    output logic                          wr_rdy_o,
    output logic                          done_o,
    output logic                          idle_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          txd_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);
    localparam logic          ODD_PAR   = (PARITY == 2);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_fifo: illegal parameter value");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            level_q;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   push, pop, empty, baud_end;
    logic [DATA_BITS-1:0]   head;

    assign empty    = (level_q == '0);
    assign wr_rdy_o = (level_q != FULL);
    assign push     = wr_vld_i && wr_rdy_o;
    assign baud_end = (baud_q == BAUD_LAST);
    assign head     = mem_q[rd_ptr_q];

    assign idle_o  = empty && (state_q == S_IDLE);
    assign level_o = level_q;
    assign txd_o   = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        done_o  = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        done_o = 1'b1;
                        if (!empty) pop = 1'b1;
                        else        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Popping always starts a fresh frame, whether from IDLE or straight out of STOP.
        if (pop) begin
            state_d = S_START;
            shift_d = head;
            par_d   = (^head) ^ ODD_PAR;
            tx_d    = 1'b0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat_i;
    end
endmodule
